// File: rtl/esc_pkg.sv
// esc_pkg: shared types, default timing constants and pulse-width arithmetic for the ESC driver
// Contents: FSM state enum, PERIOD/MIN/MAX/SCALE defaults, speed/trim/pulse typedefs, pw_calc helper.
package esc_pkg;

    typedef enum logic [1:0] {DISARMED, RUN, FAILSAFE} state_e;

    localparam int PERIOD_D    = 1_000_000;
    localparam int MIN_PULSE_D = 50_000;
    localparam int MAX_PULSE_D = 100_000;
    localparam int SCALE_D     = 24;

    typedef logic [10:0]        spd_t;
    typedef logic signed [9:0]  trim_t;
    typedef logic [19:0]        pulse_t;

    // Offset + scale in 20 bits, then the signed trim is added in a wider signed
    // domain so a negative trim below MIN clamps up instead of wrapping to a huge width.
    function automatic pulse_t pw_calc(input spd_t spd, input trim_t trim,
                                       input int mn, input int mx, input int sc);
        logic signed [21:0] raw, lo, hi;
        lo  = $signed({2'b00, pulse_t'(mn)});
        hi  = $signed({2'b00, pulse_t'(mx)});
        raw = $signed({2'b00, pulse_t'(pulse_t'(mn) + pulse_t'(sc) * pulse_t'(spd))}) + 22'(trim);
        return raw < lo ? pulse_t'(mn) : raw > hi ? pulse_t'(mx) : raw[19:0];
    endfunction

endpackage

// File: rtl/esc_quad_drv_if.sv
// esc_quad_drv_if: controller-to-ESC-driver bundle (speeds + strobe in, pulses + status out)
// Signals: vld, frnt/bck/lft/rght_spd (11b), trim_* (10b signed, only with ESC_TRIM_EN),
//          pwm_frnt/bck/lft/rght, frm_strt, armed, stale.
// master = flight controller side, slave = esc_quad_drv.
interface esc_quad_drv_if;
    logic          vld;
    esc_pkg::spd_t frnt_spd, bck_spd, lft_spd, rght_spd;
`ifdef ESC_TRIM_EN
    esc_pkg::trim_t trim_frnt, trim_bck, trim_lft, trim_rght;
`endif
    logic pwm_frnt, pwm_bck, pwm_lft, pwm_rght, frm_strt, armed, stale;

    modport master (
`ifdef ESC_TRIM_EN
        output trim_frnt, trim_bck, trim_lft, trim_rght,
`endif
        output vld, frnt_spd, bck_spd, lft_spd, rght_spd,
        input  pwm_frnt, pwm_bck, pwm_lft, pwm_rght, frm_strt, armed, stale
    );

    modport slave (
`ifdef ESC_TRIM_EN
        input  trim_frnt, trim_bck, trim_lft, trim_rght,
`endif
        input  vld, frnt_spd, bck_spd, lft_spd, rght_spd,
        output pwm_frnt, pwm_bck, pwm_lft, pwm_rght, frm_strt, armed, stale
    );
endinterface

// File: rtl/esc_chan.sv
// esc_chan: one ESC channel - shadow capture, width computation, active register, pulse comparator
// Ports: clk, rst, i_vld (capture strobe), i_spd/i_trim (raw inputs), i_frm (frame-start cycle),
//        i_run (use computed width, else MIN_PULSE), i_cnt (frame counter), o_pwm (registered pulse).
module esc_chan
    import esc_pkg::*;
#(
    parameter int MIN_PULSE = MIN_PULSE_D,
    parameter int MAX_PULSE = MAX_PULSE_D,
    parameter int SCALE     = SCALE_D
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   i_vld,
    input  spd_t   i_spd,
    input  trim_t  i_trim,
    input  logic   i_frm,
    input  logic   i_run,
    input  pulse_t i_cnt,
    output logic   o_pwm
);
    spd_t   r_spd;
    trim_t  r_trim;
    pulse_t r_act, w_act;
    logic   r_pwm;

    // The frame-start edge loads from the shadow as it stood before that edge,
    // and the comparator uses the width being loaded so the pulse rises at cnt==1.
    always_comb w_act = !i_frm ? r_act :
                        i_run  ? pw_calc(r_spd, r_trim, MIN_PULSE, MAX_PULSE, SCALE) :
                                 pulse_t'(MIN_PULSE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_spd  <= '0;
            r_trim <= '0;
            r_act  <= '0;
            r_pwm  <= 1'b0;
        end else begin
            if (i_vld) begin
                r_spd  <= i_spd;
                r_trim <= i_trim;
            end
            r_act <= w_act;
            r_pwm <= i_cnt < w_act;
        end
    end

    assign o_pwm = r_pwm;
endmodule

// File: rtl/esc_quad_drv.sv
// esc_quad_drv: four-channel servo-style ESC pulse generator with arming sequence and stale failsafe
// Ports: clk, rst (sync, active high), bus (esc_quad_drv_if.slave: speeds/vld in, pwm/status out).
// Optional: define ESC_TRIM_EN to add signed per-channel trims sampled with vld.
module esc_quad_drv
    import esc_pkg::*;
#(
    parameter int PERIOD       = PERIOD_D,
    parameter int MIN_PULSE    = MIN_PULSE_D,
    parameter int MAX_PULSE    = MAX_PULSE_D,
    parameter int SCALE        = SCALE_D,
    parameter int ARM_FRAMES   = 50,
    parameter int STALE_FRAMES = 4
) (
    input logic           clk,
    input logic           rst,
    esc_quad_drv_if.slave bus
);
    pulse_t      r_cnt;
    state_e      r_st, w_st;
    logic [15:0] r_arm, r_stl;
    logic        r_seen, w_frm, w_run;
    spd_t        w_spd  [4];
    trim_t       w_trim [4];
    logic [3:0]  w_pwm;

    // Gated by rst so frm_strt stays low while reset is held yet fires on the
    // very first cycle after release, when cnt already sits at 0.
    always_comb begin
        w_frm = r_cnt == '0 && !rst;
        w_st  = !w_frm               ? r_st :
                r_st == DISARMED     ? (r_arm == 16'(ARM_FRAMES) ? RUN : DISARMED) :
                r_st == RUN          ? (!r_seen && r_stl == 16'(STALE_FRAMES - 1) ? FAILSAFE : RUN) :
                r_seen               ? RUN : FAILSAFE;
        w_run = w_st == RUN;
    end

    // seen restarts at each frame start; a vld on that same cycle belongs to the new frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_st   <= DISARMED;
            r_arm  <= '0;
            r_stl  <= '0;
            r_seen <= 1'b0;
        end else begin
            r_cnt  <= r_cnt == pulse_t'(PERIOD - 1) ? '0 : r_cnt + 1'b1;
            r_st   <= w_st;
            r_seen <= w_frm ? bus.vld : r_seen | bus.vld;
            r_arm  <= w_frm && r_st == DISARMED ? r_arm + 1'b1 : r_arm;
            r_stl  <= r_st != RUN || (w_frm && r_seen) ? '0 : w_frm ? r_stl + 1'b1 : r_stl;
        end
    end

    assign w_spd = '{bus.frnt_spd, bus.bck_spd, bus.lft_spd, bus.rght_spd};
`ifdef ESC_TRIM_EN
    assign w_trim = '{bus.trim_frnt, bus.trim_bck, bus.trim_lft, bus.trim_rght};
`else
    assign w_trim = '{default: '0};
`endif

    for (genvar c = 0; c < 4; c++) begin : g_ch
        esc_chan #(
            .MIN_PULSE(MIN_PULSE),
            .MAX_PULSE(MAX_PULSE),
            .SCALE    (SCALE)
        ) u_chan (
            .clk   (clk),
            .rst   (rst),
            .i_vld (bus.vld),
            .i_spd (w_spd[c]),
            .i_trim(w_trim[c]),
            .i_frm (w_frm),
            .i_run (w_run),
            .i_cnt (r_cnt),
            .o_pwm (w_pwm[c])
        );
    end

    assign bus.pwm_frnt = w_pwm[0];
    assign bus.pwm_bck  = w_pwm[1];
    assign bus.pwm_lft  = w_pwm[2];
    assign bus.pwm_rght = w_pwm[3];
    assign bus.frm_strt = w_frm;
    assign bus.armed    = r_st != DISARMED;
    assign bus.stale    = r_st == FAILSAFE;
endmodule

// File: tb/tb_esc_quad_drv.sv
// tb_esc_quad_drv: frame-level directed bench for esc_quad_drv with shortened timing parameters
module tb_esc_quad_drv;
    localparam int P  = 128;
    localparam int MN = 16;
    localparam int MX = 100;
    localparam int SC = 3;
    localparam int AF = 3;
    localparam int SF = 4;

    typedef struct {
        bit v;
        int off;
        int s  [4];
        int tr [4];
        int w  [4];
        bit a;
        bit st;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_run = 0;
    int   n_fail = 0;
    vec_t tbl [16];

    esc_quad_drv_if bus();

    esc_quad_drv #(
        .PERIOD(P), .MIN_PULSE(MN), .MAX_PULSE(MX), .SCALE(SC),
        .ARM_FRAMES(AF), .STALE_FRAMES(SF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_run++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(bit v, int off, int s0, int s1, int s2, int s3,
                                int w0, int w1, int w2, int w3, bit a, bit st);
        vec_t t;
        t.v = v; t.off = off; t.a = a; t.st = st;
        t.s  = '{s0, s1, s2, s3};
        t.tr = '{0, 0, 0, 0};
        t.w  = '{w0, w1, w2, w3};
        return t;
    endfunction

    // Entered on a frame-start cycle; measures one frame and ends on the next frame-start cycle.
    task automatic run_frame(input vec_t t, input int idx);
        int k, cw[4], tot[4];
        bit on[4];
        bit done;
        logic a, s;
        logic [3:0] p;
        bus.frnt_spd = 11'(t.s[0]);
        bus.bck_spd  = 11'(t.s[1]);
        bus.lft_spd  = 11'(t.s[2]);
        bus.rght_spd = 11'(t.s[3]);
`ifdef ESC_TRIM_EN
        bus.trim_frnt = 10'(t.tr[0]);
        bus.trim_bck  = 10'(t.tr[1]);
        bus.trim_lft  = 10'(t.tr[2]);
        bus.trim_rght = 10'(t.tr[3]);
`endif
        for (int c = 0; c < 4; c++) begin
            cw[c] = 0; tot[c] = 0; on[c] = 1'b1;
        end
        a = 1'b0; s = 1'b0; k = 0; done = 1'b0;
        bus.vld = t.v && t.off == 0;
        while (!done && k < P + 2) begin
            tick;
            k++;
            bus.vld = t.v && k == t.off;
            p = {bus.pwm_rght, bus.pwm_lft, bus.pwm_bck, bus.pwm_frnt};
            if (k == 1) begin
                a = bus.armed;
                s = bus.stale;
            end
            if (bus.frm_strt) done = 1'b1;
            else for (int c = 0; c < 4; c++) begin
                if (p[c] && on[c]) cw[c]++;
                else on[c] = 1'b0;
                tot[c] += int'(p[c]);
            end
        end
        bus.vld = 1'b0;
        chk($sformatf("f%0d period", idx), k, P);
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("f%0d ch%0d width", idx, c), cw[c], t.w[c]);
            chk($sformatf("f%0d ch%0d high_total", idx, c), tot[c], t.w[c]);
        end
        chk($sformatf("f%0d armed", idx), int'(a), int'(t.a));
        chk($sformatf("f%0d stale", idx), int'(s), int'(t.st));
    endtask

    initial begin
        vec_t t;
        tbl[0]  = mk(1, 10,    5, 5,  5,  5,   16, 16,  16,  16, 0, 0);
        tbl[1]  = mk(1, 10,    5, 5,  5,  5,   16, 16,  16,  16, 0, 0);
        tbl[2]  = mk(1, 10,    5, 5,  5,  5,   16, 16,  16,  16, 0, 0);
        tbl[3]  = mk(1, 10, 2047, 0, 28, 29,   31, 31,  31,  31, 1, 0);
        tbl[4]  = mk(1, 10,   10, 20, 1,  2,  100, 16, 100, 100, 1, 0);
        tbl[5]  = mk(1,  0,    8, 8,  8,  8,   46, 76,  19,  22, 1, 0);
        tbl[6]  = mk(0,  0,    0, 0,  0,  0,   40, 40,  40,  40, 1, 0);
        tbl[7]  = mk(0,  0,    0, 0,  0,  0,   40, 40,  40,  40, 1, 0);
        tbl[8]  = mk(0,  0,    0, 0,  0,  0,   40, 40,  40,  40, 1, 0);
        tbl[9]  = mk(0,  0,    0, 0,  0,  0,   40, 40,  40,  40, 1, 0);
        tbl[10] = mk(1, 10,    9, 4,  0, 12,   16, 16,  16,  16, 1, 1);
        tbl[11] = mk(0,  0,    0, 0,  0,  0,   43, 28,  16,  52, 1, 0);
        tbl[12] = mk(0,  0,    0, 0,  0,  0,   16, 16,  16,  16, 0, 0);
        tbl[13] = mk(0,  0,    0, 0,  0,  0,   16, 16,  16,  16, 0, 0);
        tbl[14] = mk(0,  0,    0, 0,  0,  0,   16, 16,  16,  16, 0, 0);
        tbl[15] = mk(0,  0,    0, 0,  0,  0,   16, 16,  16,  16, 1, 0);

        rst = 1'b1;
        bus.vld = 1'b0;
        bus.frnt_spd = '0; bus.bck_spd = '0; bus.lft_spd = '0; bus.rght_spd = '0;
`ifdef ESC_TRIM_EN
        bus.trim_frnt = '0; bus.trim_bck = '0; bus.trim_lft = '0; bus.trim_rght = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("reset pwm", int'({bus.pwm_frnt, bus.pwm_bck, bus.pwm_lft, bus.pwm_rght}), 0);
        chk("reset frm_strt", int'(bus.frm_strt), 0);
        chk("reset armed", int'(bus.armed), 0);
        chk("reset stale", int'(bus.stale), 0);
        rst = 1'b0;
        #1;
        chk("first frm_strt", int'(bus.frm_strt), 1);

        for (int i = 0; i < 12; i++) run_frame(tbl[i], i);

`ifdef ESC_TRIM_EN
        t = tbl[11];
        t.v = 1'b1; t.off = 10;
        t.s  = '{0, 2047, 5, 10};
        t.tr = '{-100, 511, -10, 20};
        run_frame(t, 100);
        t.v = 1'b0;
        t.w = '{16, 100, 21, 66};
        run_frame(t, 101);
`endif

        repeat (5) tick;
        chk("pre-reset pulse high", int'(bus.pwm_frnt), 1);
        rst = 1'b1;
        tick;
        chk("mid-pulse reset pwm", int'({bus.pwm_frnt, bus.pwm_bck, bus.pwm_lft, bus.pwm_rght}), 0);
        chk("mid-pulse reset frm_strt", int'(bus.frm_strt), 0);
        chk("mid-pulse reset armed", int'(bus.armed), 0);
        chk("mid-pulse reset stale", int'(bus.stale), 0);
        rst = 1'b0;
        #1;
        chk("frm_strt after release", int'(bus.frm_strt), 1);

        for (int i = 12; i < 16; i++) run_frame(tbl[i], i);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
